ddrphy_cmd_pipe: RTL and testbench
==================================

DDRPHY_CMD_PIPE -- requirements
Module: ddrphy_cmd_pipe

Parameters
REQ-001 SHALL provide parameter CS_WIDTH, default 1: number of chip selects / ranks.
REQ-002 SHALL provide parameter BA_WIDTH, default 3: bank-address width.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 14: row/column address width.
REQ-004 SHALL provide parameter MAX_LAT, default 4: maximum programmable extra command latency in cycles (>=0).

Interface
REQ-005 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port cfg_lat, input, $clog2(MAX_LAT+1): extra pipeline stages, quasi-static.
REQ-008 SHALL have port cfg_2t, input, 1: 1 = 2T command timing, 0 = 1T; quasi-static.
REQ-009 SHALL have ports dfi_cke, dfi_cs_n, dfi_odt, input, CS_WIDTH each: DFI per-rank controls.
REQ-010 SHALL have ports dfi_ras_n, dfi_cas_n, dfi_we_n, input, 1 each: DFI command.
REQ-011 SHALL have ports dfi_ba, input, BA_WIDTH, and dfi_addr, input, ADDR_WIDTH: DFI address.
REQ-012 SHALL have ports cke, cs_n, odt, output, CS_WIDTH each: registered DRAM pin drives.
REQ-013 SHALL have ports ras_n, cas_n, we_n, output, 1 each; ba, output, BA_WIDTH; addr, output, ADDR_WIDTH.
REQ-014 SHALL have port cmd_err, output, 1: one-cycle pulse when a command is dropped in 2T mode.
REQ-015 SHALL have port cmd_cnt, output, 16: count of commands issued to the pins.

Function
REQ-016 A "command" SHALL be any cycle with at least one cs_n bit low.
REQ-017 SHALL delay every DFI field through a cfg_lat-deep shift pipeline followed by one output register; 1T latency is cfg_lat+1 cycles, input to pin.
REQ-018 With cfg_lat=0 the pipeline SHALL be bypassed: one output register only.
REQ-019 In 1T mode all fields SHALL pass unchanged at pipeline exit.
REQ-020 cke and odt SHALL always take the 1T path, whatever cfg_2t is.
REQ-021 2T mode SHALL use an FSM with states IDLE and HOLD, reset to IDLE.
REQ-022 IDLE, pipeline exit not a command: fields pass through with cs_n forced all-ones; stay IDLE.
REQ-023 IDLE, pipeline exit is a command:
 - latch ba, addr, ras_n, cas_n, we_n, cs_n;
 - drive the latched ba/addr/ras_n/cas_n/we_n with cs_n all-ones;
 - go to HOLD.
REQ-024 HOLD: drive all latched fields, including latched cs_n; go to IDLE unconditionally.
REQ-025 HOLD with a new command at pipeline exit:
 - new command dropped;
 - cmd_err pulses high in the following cycle for exactly one cycle.
REQ-026 In 2T mode ba/addr/ras_n/cas_n/we_n SHALL reach the pins at cfg_lat+1 and cs_n low at cfg_lat+2; both cycles carry the same field values.
REQ-027 cmd_cnt SHALL increment by 1 on each cycle the output cs_n has any bit low, wrapping 0xFFFF->0x0000.
REQ-028 A cfg_lat or cfg_2t change outside reset SHALL leave pipeline contents undefined until cfg_lat+2 cycles later; the FSM SHALL return to IDLE when cfg_2t=0.

Reset
REQ-029 While rst=1 outputs SHALL register: cke=0, cs_n=all-ones, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=0, cmd_err=0, cmd_cnt=0.
REQ-030 Reset SHALL fill every pipeline stage with NOP (cke=0, cs_n all-ones, ras/cas/we=1, ba/addr/odt=0) and force the FSM to IDLE.
REQ-031 Reset asserted during HOLD SHALL abort the held command; cs_n SHALL NOT go low after reset.

Verification
REQ-032 cfg_lat=0, 1T, ACT (cs_n=0, ras_n=0, ba=2, addr=0x1A5) at cycle 10 -> pins carry it at cycle 11, cmd_cnt=1.
REQ-033 cfg_lat=3, 1T, back-to-back RD,WR at cycles 20,21 -> pins at 24,25 unaltered, cmd_cnt=2.
REQ-034 cfg_lat=2, 2T, WR (ba=5, addr=0x0400) at cycle 30 -> addr/ba at pins at 33 with cs_n=1; cycle 34 cs_n=0 with the same fields.
REQ-035 2T, commands at cycles 40 and 41 (cfg_lat=0) -> first issued with cs_n low at 42, second dropped, cmd_err=1 at 43 only, cmd_cnt +1.
REQ-036 rst asserted in HOLD -> next edge: all outputs at reset values, cs_n stays all-ones, cmd_cnt=0.
REQ-037 Preload cmd_cnt to 0xFFFF via 65535 commands, issue one more -> cmd_cnt=0x0000, no cmd_err.

Source files
------------

// File: rtl/ddrphy_cmd_pipe.sv
// DFI-to-DRAM command pipe: programmable extra latency, then a 1T/2T command
// shaper with a single output register on every pin and an issued-command counter.
module ddrphy_cmd_pipe #(
    parameter int CS_WIDTH   = 1,
    parameter int BA_WIDTH   = 3,
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_LAT    = 4,
    localparam int LAT_W     = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LAT_W-1:0]      cfg_lat,
    input  logic                  cfg_2t,
    input  logic [CS_WIDTH-1:0]   dfi_cke,
    input  logic [CS_WIDTH-1:0]   dfi_cs_n,
    input  logic [CS_WIDTH-1:0]   dfi_odt,
    input  logic                  dfi_ras_n,
    input  logic                  dfi_cas_n,
    input  logic                  dfi_we_n,
    input  logic [BA_WIDTH-1:0]   dfi_ba,
    input  logic [ADDR_WIDTH-1:0] dfi_addr,
    output logic [CS_WIDTH-1:0]   cke,
    output logic [CS_WIDTH-1:0]   cs_n,
    output logic [CS_WIDTH-1:0]   odt,
    output logic                  ras_n,
    output logic                  cas_n,
    output logic                  we_n,
    output logic [BA_WIDTH-1:0]   ba,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  cmd_err,
    output logic [15:0]           cmd_cnt
);

    // state | meaning
    // IDLE  | pass-through; a command at pipe exit is latched and sent with cs_n high
    // HOLD  | second 2T cycle: latched command driven with its cs_n; new commands dropped

    localparam int DEPTH = (MAX_LAT > 0) ? MAX_LAT : 1;

    typedef struct packed {
        logic [CS_WIDTH-1:0]   cke;
        logic [CS_WIDTH-1:0]   cs_n;
        logic [CS_WIDTH-1:0]   odt;
        logic                  ras_n;
        logic                  cas_n;
        logic                  we_n;
        logic [BA_WIDTH-1:0]   ba;
        logic [ADDR_WIDTH-1:0] addr;
    } cmd_t;

    typedef enum logic {IDLE, HOLD} state_t;

    function automatic cmd_t nop_cmd();
        cmd_t c;
        c       = '0;
        c.cs_n  = '1;
        c.ras_n = 1'b1;
        c.cas_n = 1'b1;
        c.we_n  = 1'b1;
        return c;
    endfunction

    cmd_t   dfi_in;
    cmd_t   pipe [DEPTH];
    cmd_t   pipe_exit;
    cmd_t   pin_nxt;
    cmd_t   held;
    state_t state, state_nxt;
    logic   exit_is_cmd;
    logic   held_load;
    logic   drop;
    logic   err_q;

    always_comb begin
        dfi_in.cke   = dfi_cke;
        dfi_in.cs_n  = dfi_cs_n;
        dfi_in.odt   = dfi_odt;
        dfi_in.ras_n = dfi_ras_n;
        dfi_in.cas_n = dfi_cas_n;
        dfi_in.we_n  = dfi_we_n;
        dfi_in.ba    = dfi_ba;
        dfi_in.addr  = dfi_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= nop_cmd();
        end else begin
            pipe[0] <= dfi_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Picks stage cfg_lat-1; values above MAX_LAT saturate at the last stage.
    always_comb begin
        pipe_exit = dfi_in;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (cfg_lat > LAT_W'(i)) pipe_exit = pipe[i];
        end
    end

    assign exit_is_cmd = ~&pipe_exit.cs_n;

    always_comb begin
        state_nxt = IDLE;
        pin_nxt   = pipe_exit;
        held_load = 1'b0;
        drop      = 1'b0;
        if (cfg_2t) begin
            case (state)
                IDLE: begin
                    pin_nxt.cs_n = '1;
                    if (exit_is_cmd) begin
                        held_load = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    // cke/odt stay on the 1T path even while a command is held
                    pin_nxt.cs_n  = held.cs_n;
                    pin_nxt.ras_n = held.ras_n;
                    pin_nxt.cas_n = held.cas_n;
                    pin_nxt.we_n  = held.we_n;
                    pin_nxt.ba    = held.ba;
                    pin_nxt.addr  = held.addr;
                    drop          = exit_is_cmd;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            held    <= nop_cmd();
            err_q   <= 1'b0;
            cmd_err <= 1'b0;
            cmd_cnt <= 16'd0;
            cke     <= '0;
            cs_n    <= '1;
            odt     <= '0;
            ras_n   <= 1'b1;
            cas_n   <= 1'b1;
            we_n    <= 1'b1;
            ba      <= '0;
            addr    <= '0;
        end else begin
            state <= state_nxt;
            if (held_load) held <= pipe_exit;
            // the drop is flagged one cycle after the held command reaches the pins
            err_q   <= drop;
            cmd_err <= err_q;
            if (~&pin_nxt.cs_n) cmd_cnt <= cmd_cnt + 16'd1;
            cke     <= pin_nxt.cke;
            cs_n    <= pin_nxt.cs_n;
            odt     <= pin_nxt.odt;
            ras_n   <= pin_nxt.ras_n;
            cas_n   <= pin_nxt.cas_n;
            we_n    <= pin_nxt.we_n;
            ba      <= pin_nxt.ba;
            addr    <= pin_nxt.addr;
        end
    end

endmodule

// File: tb/tb_ddrphy_cmd_pipe.sv
// Randomized bench for ddrphy_cmd_pipe against a cycle-indexed command-history model.
module tb_ddrphy_cmd_pipe;

    localparam int CS = 2;
    localparam int BA = 3;
    localparam int AW = 14;
    localparam int ML = 4;
    localparam int LW = $clog2(ML + 1);

    typedef struct packed {
        logic [CS-1:0] cke;
        logic [CS-1:0] cs_n;
        logic [CS-1:0] odt;
        logic          ras_n;
        logic          cas_n;
        logic          we_n;
        logic [BA-1:0] ba;
        logic [AW-1:0] addr;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] cfg_lat = '0;
    logic          cfg_2t = 1'b0;
    logic [CS-1:0] dfi_cke = '0, dfi_cs_n = '1, dfi_odt = '0;
    logic          dfi_ras_n = 1'b1, dfi_cas_n = 1'b1, dfi_we_n = 1'b1;
    logic [BA-1:0] dfi_ba = '0;
    logic [AW-1:0] dfi_addr = '0;
    logic [CS-1:0] cke, cs_n, odt;
    logic          ras_n, cas_n, we_n, cmd_err;
    logic [BA-1:0] ba;
    logic [AW-1:0] addr;
    logic [15:0]   cmd_cnt;

    ddrphy_cmd_pipe #(.CS_WIDTH(CS), .BA_WIDTH(BA), .ADDR_WIDTH(AW), .MAX_LAT(ML)) dut (
        .clk(clk), .rst(rst), .cfg_lat(cfg_lat), .cfg_2t(cfg_2t),
        .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_odt(dfi_odt),
        .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
        .dfi_ba(dfi_ba), .dfi_addr(dfi_addr),
        .cke(cke), .cs_n(cs_n), .odt(odt), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .cmd_err(cmd_err), .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "time limit");
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    // Model: hist[k] is the DFI word sampled at edge k after reset release.
    cmd_t        hist [$];
    bit          acc  [$];
    bit          drp  [$];
    int          lat;
    bit          two_t;
    logic [15:0] cnt_m;

    function automatic cmd_t nop();
        cmd_t c;
        c = '0;
        c.cs_n = '1;
        c.ras_n = 1'b1;
        c.cas_n = 1'b1;
        c.we_n = 1'b1;
        return c;
    endfunction

    function automatic bit is_cmd(cmd_t c);
        return c.cs_n != '1;
    endfunction

    function automatic cmd_t exit_at(int k);
        return (k - lat >= 0) ? hist[k - lat] : nop();
    endfunction

    function automatic cmd_t pins();
        cmd_t c;
        c.cke = cke; c.cs_n = cs_n; c.odt = odt;
        c.ras_n = ras_n; c.cas_n = cas_n; c.we_n = we_n;
        c.ba = ba; c.addr = addr;
        return c;
    endfunction

    function automatic cmd_t rnd();
        cmd_t c;
        c.cke   = CS'($urandom);
        c.cs_n  = ($urandom_range(0, 2) == 0) ? '1 : CS'($urandom);
        c.odt   = CS'($urandom);
        c.ras_n = 1'($urandom);
        c.cas_n = 1'($urandom);
        c.we_n  = 1'($urandom);
        c.ba    = BA'($urandom);
        c.addr  = AW'($urandom);
        return c;
    endfunction

    task automatic drive(input cmd_t c);
        dfi_cke = c.cke; dfi_cs_n = c.cs_n; dfi_odt = c.odt;
        dfi_ras_n = c.ras_n; dfi_cas_n = c.cas_n; dfi_we_n = c.we_n;
        dfi_ba = c.ba; dfi_addr = c.addr;
    endtask

    task automatic do_reset(input int l, input bit t2, input bit check);
        cmd_t r;
        lat = l; two_t = t2;
        cfg_lat = LW'(l); cfg_2t = t2;
        rst = 1'b1;
        drive(nop());
        @(posedge clk); #1;
        if (check) begin
            r = nop();
            chk("rst_pins", pins(), r);
            chk("rst_cmd_err", cmd_err, 0);
            chk("rst_cmd_cnt", cmd_cnt, 0);
        end
        repeat (ML + 1) @(posedge clk);
        #1;
        rst = 1'b0;
        hist.delete(); acc.delete(); drp.delete();
        cnt_m = 16'd0;
    endtask

    // A 2T command occupies the exit cycle it is accepted in and the next one;
    // any command reaching the exit in that second cycle is lost and flagged a cycle later.
    task automatic step(input cmd_t v, input bit check);
        cmd_t x, xp, e;
        int k;
        bit pa, pd, a, d;
        drive(v);
        hist.push_back(v);
        @(posedge clk); #1;
        k  = hist.size() - 1;
        x  = exit_at(k);
        pa = (k > 0) ? acc[k-1] : 1'b0;
        pd = (k > 0) ? drp[k-1] : 1'b0;
        e = x; a = 0; d = 0;
        if (two_t) begin
            if (pa) begin
                xp = exit_at(k - 1);
                e.cs_n = xp.cs_n; e.ras_n = xp.ras_n; e.cas_n = xp.cas_n;
                e.we_n = xp.we_n; e.ba = xp.ba; e.addr = xp.addr;
                d = is_cmd(x);
            end else begin
                e.cs_n = '1;
                a = is_cmd(x);
            end
        end
        acc.push_back(a);
        drp.push_back(d);
        if (is_cmd(e)) cnt_m++;
        if (check) begin
            chk("pins", pins(), e);
            chk("cmd_err", cmd_err, pd);
            chk("cmd_cnt", cmd_cnt, cnt_m);
        end
    endtask

    function automatic cmd_t mk(input logic [CS-1:0] csn, input logic r, input logic c,
                                input logic w, input logic [BA-1:0] b, input logic [AW-1:0] a);
        cmd_t m;
        m = nop();
        m.cke = '1; m.cs_n = csn; m.ras_n = r; m.cas_n = c; m.we_n = w; m.ba = b; m.addr = a;
        return m;
    endfunction

    initial begin
        cmd_t idle_c, act, rd, wr;
        idle_c = nop(); idle_c.cke = '1;
        act = mk('0, 1'b0, 1'b1, 1'b1, 3'd2, 14'h01A5);
        rd  = mk('0, 1'b1, 1'b0, 1'b1, 3'd1, 14'h0010);
        wr  = mk('0, 1'b1, 1'b0, 1'b0, 3'd5, 14'h0400);

        // 1T, no extra latency: ACT one cycle later
        do_reset(0, 0, 1);
        repeat (3) step(idle_c, 1);
        step(act, 1);
        chk("act_addr", addr, 14'h01A5);
        chk("act_cnt", cmd_cnt, 1);
        repeat (3) step(idle_c, 1);

        // 1T, latency 3: back-to-back RD/WR unaltered
        do_reset(3, 0, 1);
        step(rd, 1); step(wr, 1);
        repeat (5) step(idle_c, 1);
        chk("rdwr_cnt", cmd_cnt, 2);

        // 2T, latency 2: WR fields early with cs_n high, then cs_n low
        do_reset(2, 1, 0);
        step(wr, 1);
        repeat (2) step(idle_c, 1);
        chk("wr2t_first_csn", cs_n, 2'b11);
        step(idle_c, 1);
        chk("wr2t_second_csn", cs_n, 2'b00);
        chk("wr2t_second_ba", ba, 3'd5);
        repeat (3) step(idle_c, 1);

        // 2T back-to-back: second dropped, cmd_err pulse
        do_reset(0, 1, 0);
        step(act, 1); step(rd, 1);
        repeat (4) step(idle_c, 1);
        chk("b2b_cnt", cmd_cnt, 1);

        // randomized segments across configurations
        for (int cfg = 0; cfg < 8; cfg++) begin
            do_reset(cfg % (ML + 1), cfg[0], 1);
            for (int i = 0; i < 150; i++) step(rnd(), 1);
        end

        // reset while a command is held: no late cs_n
        do_reset(0, 1, 0);
        step(act, 1);
        do_reset(0, 1, 1);
        repeat (4) step(idle_c, 1);

        // counter wrap
        do_reset(0, 0, 0);
        for (int i = 0; i < 65535; i++) step(act, 0);
        chk("cnt_ffff", cmd_cnt, 16'hFFFF);
        step(act, 1);
        chk("cnt_wrap", cmd_cnt, 16'h0000);
        chk("wrap_err", cmd_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
